// File: rtl/perceptron_trainer.sv
// perceptron_trainer: perceptron learning-rule engine, one shared saturating fixed-point multiplier and adder,
// walks IDLE->SCALE->UPD1->UPD2->UPDB->DONE per sample and counts misclassified samples.
module perceptron_trainer #(
  parameter int SIGN = 1,
  parameter int Q_M = 15,
  parameter int Q_N = 16,
  parameter logic [SIGN+Q_M+Q_N-1:0] BIAS = 32'h0001_0000,
  parameter logic [SIGN+Q_M+Q_N-1:0] LR = 32'h0000_8000,
  parameter logic [SIGN+Q_M+Q_N-1:0] W1_INIT = 32'h0000_0000,
  parameter logic [SIGN+Q_M+Q_N-1:0] W2_INIT = 32'h0000_0000,
  parameter logic [SIGN+Q_M+Q_N-1:0] WB_INIT = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SIGN+Q_M+Q_N-1:0]   x1_in,
  input  logic [SIGN+Q_M+Q_N-1:0]   x2_in,
  input  logic [SIGN+Q_M+Q_N-1:0]   target,
  input  logic [SIGN+Q_M+Q_N-1:0]   prediction,
  input  logic                      load_en,
  input  logic [SIGN+Q_M+Q_N-1:0]   w1_load,
  input  logic [SIGN+Q_M+Q_N-1:0]   w2_load,
  input  logic [SIGN+Q_M+Q_N-1:0]   wb_load,
  input  logic                      clear_count,
  output logic [SIGN+Q_M+Q_N-1:0]   w1,
  output logic [SIGN+Q_M+Q_N-1:0]   w2,
  output logic [SIGN+Q_M+Q_N-1:0]   wb,
  output logic                      update_done,
  output logic [CNT_W-1:0]          err_count
);
  localparam int W = SIGN + Q_M + Q_N;
  localparam logic [2:0] IDLE = 3'd0, SCALE = 3'd1, UPD1 = 3'd2, UPD2 = 3'd3, UPDB = 3'd4, DONE = 3'd5;
  localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

  logic [2:0] state_q, state_d;
  logic [W-1:0] w1_q, w1_d, w2_q, w2_d, wb_q, wb_d;
  logic [W-1:0] x1_q, x1_d, x2_q, x2_d, err_q, err_d, es_q, es_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] mul_a, mul_b, mul_r, add_a, add_b, add_r;
  logic signed [2*W-1:0] prod, prod_sh;
  logic [W:0] sum;
  logic sub;

  // Shared datapath: operands steered by state; IDLE reuses the adder to form target - prediction.
  always_comb begin
    mul_a = state_q == SCALE ? LR : es_q;
    mul_b = state_q == SCALE ? err_q : state_q == UPD1 ? x1_q : state_q == UPD2 ? x2_q : BIAS;
    prod = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
    prod_sh = prod >>> Q_N;
    mul_r = (&prod_sh[2*W-1:W-1] | ~|prod_sh[2*W-1:W-1]) ? prod_sh[W-1:0] : prod_sh[2*W-1] ? MINV : MAXV;
    sub = state_q == IDLE;
    add_a = sub ? target : state_q == UPD1 ? w1_q : state_q == UPD2 ? w2_q : wb_q;
    add_b = sub ? prediction : mul_r;
    sum = {add_a[W-1], add_a} + (sub ? ~{add_b[W-1], add_b} : {add_b[W-1], add_b}) + {{W{1'b0}}, sub};
    add_r = sum[W] == sum[W-1] ? sum[W-1:0] : sum[W] ? MINV : MAXV;
  end

  always_comb begin
    state_d = state_q;
    w1_d = w1_q;
    w2_d = w2_q;
    wb_d = wb_q;
    x1_d = x1_q;
    x2_d = x2_q;
    err_d = err_q;
    es_d = es_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          w1_d = w1_load;
          w2_d = w2_load;
          wb_d = wb_load;
        end else if (in_valid) begin
          x1_d = x1_in;
          x2_d = x2_in;
          err_d = add_r;
          state_d = SCALE;
        end
      end
      SCALE: begin
        es_d = mul_r;
        cnt_d = (err_q != '0 && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
        state_d = UPD1;
      end
      UPD1: begin
        w1_d = add_r;
        state_d = UPD2;
      end
      UPD2: begin
        w2_d = add_r;
        state_d = UPDB;
      end
      UPDB: begin
        wb_d = add_r;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (clear_count) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      w1_q <= W1_INIT;
      w2_q <= W2_INIT;
      wb_q <= WB_INIT;
      x1_q <= '0;
      x2_q <= '0;
      err_q <= '0;
      es_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      w1_q <= w1_d;
      w2_q <= w2_d;
      wb_q <= wb_d;
      x1_q <= x1_d;
      x2_q <= x2_d;
      err_q <= err_d;
      es_q <= es_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready = state_q == IDLE;
  assign update_done = state_q == DONE;
  assign w1 = w1_q;
  assign w2 = w2_q;
  assign wb = wb_q;
  assign err_count = cnt_q;
endmodule
